// File: rtl/telemetry_sampler_if.sv
// Telemetry sampler bus: raw statistics and vsync in, per-frame snapshot out.
// sat_flags exists only when TELEMETRY_SAMPLER_SAT_FLAG_EN is defined.
interface telemetry_sampler_if #(
  parameter int RAW_WIDTH   = 16,
  parameter int VALUE_WIDTH = 9
);
  logic                   vsync;
  logic [RAW_WIDTH-1:0]   score_raw;
  logic [RAW_WIDTH-1:0]   lines_raw;
  logic [RAW_WIDTH-1:0]   level_raw;
  logic [RAW_WIDTH-1:0]   speed_raw;
  logic [RAW_WIDTH-1:0]   rows_raw;
  logic [RAW_WIDTH-1:0]   cols_raw;
  logic [VALUE_WIDTH-1:0] sig0, sig1, sig2, sig3, sig4, sig5, sig6;
  logic                   fps_valid;
  logic                   frame_event;
`ifdef TELEMETRY_SAMPLER_SAT_FLAG_EN
  logic [6:0]             sat_flags;
`endif

  modport master (
    output vsync, score_raw, lines_raw, level_raw, speed_raw, rows_raw, cols_raw,
    input  sig0, sig1, sig2, sig3, sig4, sig5, sig6, fps_valid, frame_event
`ifdef TELEMETRY_SAMPLER_SAT_FLAG_EN
    , input sat_flags
`endif
  );

  modport slave (
    input  vsync, score_raw, lines_raw, level_raw, speed_raw, rows_raw, cols_raw,
    output sig0, sig1, sig2, sig3, sig4, sig5, sig6, fps_valid, frame_event
`ifdef TELEMETRY_SAMPLER_SAT_FLAG_EN
    , output sat_flags
`endif
  );
endinterface

// File: rtl/telemetry_sampler.sv
// Per-frame saturated snapshot of seven statistics plus vsync-derived FPS; latency 1 cycle
// from the vsync rising edge, no backpressure. Optional clip flags: TELEMETRY_SAMPLER_SAT_FLAG_EN.
module telemetry_sampler #(
  parameter int CLK_HZ      = 25_000_000,
  parameter int RAW_WIDTH   = 16,
  parameter int VALUE_WIDTH = 9
) (
  input  logic                clk,
  input  logic                reset,
  telemetry_sampler_if.slave  bus
);
  localparam int WIN_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [VALUE_WIDTH-1:0] SAT_MAX   = '1;
  localparam logic [VALUE_WIDTH:0]   FRM_SAT   = {1'b1, {VALUE_WIDTH{1'b0}}};
  localparam logic [VALUE_WIDTH+1:0] SAT_MAX_W = {2'b00, SAT_MAX};

  typedef enum logic {WARMUP, RUN} state_t;

  state_t                 state, state_nxt;
  logic                   vsync_q, rise, win_end, fps_valid_c;
  logic [WIN_W-1:0]       win_cnt;
  logic [VALUE_WIDTH:0]   frm_cnt;
  logic [VALUE_WIDTH+1:0] frm_total;
  logic [VALUE_WIDTH-1:0] fps_reg, fps_calc;
  logic [VALUE_WIDTH-1:0] snap     [7];
  logic [VALUE_WIDTH-1:0] snap_nxt [7];

  function automatic logic [VALUE_WIDTH-1:0] sat(input logic [RAW_WIDTH-1:0] raw);
    if (raw > RAW_WIDTH'(SAT_MAX)) return SAT_MAX;
    return raw[VALUE_WIDTH-1:0];
  endfunction

  function automatic logic clip(input logic [RAW_WIDTH-1:0] raw);
    return raw > RAW_WIDTH'(SAT_MAX);
  endfunction

  assign rise    = bus.vsync & ~vsync_q;
  assign win_end = (win_cnt == WIN_W'(CLK_HZ - 1));

  // A frame edge landing on win_end still belongs to the window that is closing.
  assign frm_total = {1'b0, frm_cnt} + (VALUE_WIDTH+2)'(rise);
  assign fps_calc  = (frm_total > SAT_MAX_W) ? SAT_MAX : frm_total[VALUE_WIDTH-1:0];

  always_comb begin
    snap_nxt[0] = sat(bus.score_raw);
    snap_nxt[1] = sat(bus.lines_raw);
    snap_nxt[2] = sat(bus.level_raw);
    snap_nxt[3] = sat(bus.speed_raw);
    snap_nxt[4] = fps_reg;
    snap_nxt[5] = sat(bus.rows_raw);
    snap_nxt[6] = sat(bus.cols_raw);
  end

  always_comb begin
    state_nxt   = state;
    fps_valid_c = 1'b0;
    case (state)
      WARMUP: if (win_end) state_nxt = RUN;
      RUN:    fps_valid_c = 1'b1;
      default: state_nxt = WARMUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WARMUP;
    end else begin
      state <= state_nxt;
    end
  end

  // vsync_q resets high so a vsync already asserted at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q     <= 1'b1;
      win_cnt     <= '0;
      frm_cnt     <= '0;
      fps_reg     <= '0;
      bus.frame_event <= 1'b0;
      for (int i = 0; i < 7; i++) snap[i] <= '0;
    end else begin
      vsync_q         <= bus.vsync;
      bus.frame_event <= rise;
      win_cnt         <= win_end ? '0 : win_cnt + WIN_W'(1);
      if (win_end) begin
        fps_reg <= fps_calc;
        frm_cnt <= '0;
      end else if (rise && (frm_cnt != FRM_SAT)) begin
        frm_cnt <= frm_cnt + (VALUE_WIDTH+1)'(1);
      end
      if (rise) begin
        for (int i = 0; i < 7; i++) snap[i] <= snap_nxt[i];
      end
    end
  end

`ifdef TELEMETRY_SAMPLER_SAT_FLAG_EN
  logic       fps_clip;
  logic [6:0] flags_nxt;

  always_comb begin
    flags_nxt = {clip(bus.cols_raw), clip(bus.rows_raw), fps_clip, clip(bus.speed_raw),
                 clip(bus.level_raw), clip(bus.lines_raw), clip(bus.score_raw)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fps_clip      <= 1'b0;
      bus.sat_flags <= '0;
    end else begin
      if (win_end) fps_clip <= (frm_total > SAT_MAX_W);
      if (rise)    bus.sat_flags <= flags_nxt;
    end
  end
`endif

  assign bus.sig0      = snap[0];
  assign bus.sig1      = snap[1];
  assign bus.sig2      = snap[2];
  assign bus.sig3      = snap[3];
  assign bus.sig4      = snap[4];
  assign bus.sig5      = snap[5];
  assign bus.sig6      = snap[6];
  assign bus.fps_valid = fps_valid_c;
endmodule

// File: tb/tb_telemetry_sampler.sv
// Scoreboard bench for telemetry_sampler with a 100-cycle FPS window.
module tb_telemetry_sampler;
  localparam int CLK_HZ = 100;

  logic clk;
  logic reset;

  telemetry_sampler_if #(.RAW_WIDTH(16), .VALUE_WIDTH(9)) bus();

  telemetry_sampler #(.CLK_HZ(CLK_HZ), .RAW_WIDTH(16), .VALUE_WIDTH(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [6:0][8:0] sig;
    logic [6:0]      flags;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  exp_t            mon_x;
  logic [6:0][8:0] mon_act;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] clip9(input logic [15:0] v);
    return (v > 16'd511) ? 9'd511 : v[8:0];
  endfunction

  function automatic logic over(input logic [15:0] v);
    return v > 16'd511;
  endfunction

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_raw(input logic [15:0] sc, ln, lv, sp, rw, cl);
    bus.score_raw = sc;
    bus.lines_raw = ln;
    bus.level_raw = lv;
    bus.speed_raw = sp;
    bus.rows_raw  = rw;
    bus.cols_raw  = cl;
  endtask

  // Drive a one-cycle vsync pulse so the rising edge is seen at clock edge e.
  task automatic frame_at(input int e, input logic [8:0] fps_exp);
    exp_t x;
    while (cyc < e) tick();
    x.sig[0] = clip9(bus.score_raw);
    x.sig[1] = clip9(bus.lines_raw);
    x.sig[2] = clip9(bus.level_raw);
    x.sig[3] = clip9(bus.speed_raw);
    x.sig[4] = fps_exp;
    x.sig[5] = clip9(bus.rows_raw);
    x.sig[6] = clip9(bus.cols_raw);
    x.flags  = {over(bus.cols_raw), over(bus.rows_raw), 1'b0, over(bus.speed_raw),
                over(bus.level_raw), over(bus.lines_raw), over(bus.score_raw)};
    exp_q.push_back(x);
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sig0"}, int'(bus.sig0), 0);
    check({tag, " sig1"}, int'(bus.sig1), 0);
    check({tag, " sig2"}, int'(bus.sig2), 0);
    check({tag, " sig3"}, int'(bus.sig3), 0);
    check({tag, " sig4"}, int'(bus.sig4), 0);
    check({tag, " sig5"}, int'(bus.sig5), 0);
    check({tag, " sig6"}, int'(bus.sig6), 0);
    check({tag, " fps_valid"}, int'(bus.fps_valid), 0);
    check({tag, " frame_event"}, int'(bus.frame_event), 0);
  endtask

  always @(negedge clk) begin
    if (reset && bus.frame_event) begin
      if (exp_q.size() == 0) begin
        check("spurious frame_event", 1, 0);
      end else begin
        mon_x   = exp_q.pop_front();
        mon_act = {bus.sig6, bus.sig5, bus.sig4, bus.sig3, bus.sig2, bus.sig1, bus.sig0};
        for (int i = 0; i < 7; i++)
          check($sformatf("snapshot sig%0d", i), int'(mon_act[i]), int'(mon_x.sig[i]));
`ifdef TELEMETRY_SAMPLER_SAT_FLAG_EN
        check("snapshot sat_flags", int'(bus.sat_flags), int'(mon_x.flags));
`endif
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.vsync = 1'b1;
    set_raw(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    #2 reset = 1'b0;
    #1 check_idle("in reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    reset = 1'b1;
    cyc   = 0;

    // vsync held high through release: no edge
    repeat (10) tick();
    check_idle("vsync held");
    bus.vsync = 1'b0;

    // basic snapshot, then raw change without an edge
    set_raw(16'd37, 16'd0, 16'd0, 16'd0, 16'd20, 16'd10);
    frame_at(11, 9'd0);
    bus.score_raw = 16'd99;
    while (cyc < 15) tick();
    check("sig0 hold", int'(bus.sig0), 37);

    // saturation at and above the ceiling
    set_raw(16'd1000, 16'd511, 16'd512, 16'd5, 16'd20, 16'd10);
    frame_at(15, 9'd0);

    // window 0: edges at 11,15,20..90 -> 10 frames
    set_raw(16'd1, 16'd2, 16'd3, 16'd4, 16'd20, 16'd10);
    for (int e = 20; e <= 90; e += 10) frame_at(e, 9'd0);
    while (cyc < 99) tick();
    check("fps_valid before first win_end", int'(bus.fps_valid), 0);
    tick();
    check("fps_valid after first win_end", int'(bus.fps_valid), 1);

    // window 1: edges 100..190 plus one exactly on win_end (199) -> 11
    for (int e = 100; e <= 190; e += 10) frame_at(e, 9'd10);
    frame_at(199, 9'd10);

    // window 2: 201,220..280 -> 5; frm_cnt must have restarted at 0
    frame_at(201, 9'd11);
    for (int e = 220; e <= 280; e += 20) frame_at(e, 9'd11);
    frame_at(300, 9'd5);

    // window 3: four frames then reset mid-window
    for (int e = 310; e <= 330; e += 10) frame_at(e, 9'd5);
    while (cyc < 350) tick();
    reset = 1'b0;
    #1 check_idle("mid-window reset");
    tick();
    tick();
    reset = 1'b1;
    cyc   = 0;
    for (int e = 10; e <= 90; e += 20) frame_at(e, 9'd0);
    while (cyc < 99) tick();
    check("fps_valid warmup after reset", int'(bus.fps_valid), 0);
    tick();
    check("fps_valid run after reset", int'(bus.fps_valid), 1);
    frame_at(110, 9'd5);

    repeat (5) tick();
    check("pending snapshots", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/telemetry_sampler.md
Name: telemetry_sampler

Overview:
Upstream feeder for the telemetry overlay. It snapshots seven game/debug statistics once per frame so the 7-line text panel never tears mid-frame. It saturates each statistic to 9 bits and measures frames-per-second internally from the VGA vsync. Its sig0..sig6 outputs wire directly to the overlay's sig0..sig6 inputs (SCORE, LINES, LEVEL, SPEED, FPS, ROWS, COLS).

Parameters:
CLK_HZ, 25_000_000, clock cycles per one-second FPS measurement window (bench uses 100)
RAW_WIDTH, 16, width of raw statistic inputs
VALUE_WIDTH, 9, output value width; saturation ceiling SAT_MAX = 2**VALUE_WIDTH-1 (511)

Ports:
clk  input  1  system/pixel clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
vsync  input  1  level vsync from VGA controller, active-high; rising edge = frame event
score_raw  input  RAW_WIDTH  raw score
lines_raw  input  RAW_WIDTH  raw cleared lines
level_raw  input  RAW_WIDTH  raw level
speed_raw  input  RAW_WIDTH  raw drop speed
rows_raw  input  RAW_WIDTH  raw board rows
cols_raw  input  RAW_WIDTH  raw board cols
sig0..sig6  output  VALUE_WIDTH each  snapshot: score, lines, level, speed, fps, rows, cols
fps_valid  output  1  high once the first full FPS window has completed
frame_event  output  1  registered one-cycle pulse, high the cycle after a detected vsync rising edge

Behaviour:
- Reset (reset=0, async): all sig* = 0, fps_valid = 0, frame_event = 0. vsync_q = 1, so a vsync held high across reset release produces no edge. Window counter = 0, frame counter = 0, FSM = WARMUP.
- Edge detect: rise = vsync & ~vsync_q; vsync_q registers vsync every cycle.
- Saturation: each raw value maps to min(raw, SAT_MAX), purely combinational on the raw inputs.
- Snapshot: on a cycle with rise=1, sig0..sig3, sig5 and sig6 load the saturated raw values presented that same cycle. The new values are visible the next cycle (latency 1 from the edge-detect cycle). With rise=0 all sig values hold, whatever the raw inputs do.
- frame_event is asserted the same cycle the snapshot becomes visible.
- FPS measurement:
  - win_cnt counts 0..CLK_HZ-1 and wraps; win_end = (win_cnt == CLK_HZ-1).
  - frm_cnt, VALUE_WIDTH+1 bits, increments on rise and saturates at SAT_MAX+1.
  - On win_end: fps_reg = min(frm_cnt + rise, SAT_MAX). A frame edge coinciding with win_end counts in the ending window. frm_cnt then clears to 0.
  - sig4 = fps_reg, but sig4 only updates on a snapshot (rise). It shows the most recent completed-window FPS at the last frame edge.
- FSM:
  - WARMUP: fps_valid = 0 and fps_reg = 0. The first win_end moves to RUN.
  - RUN: fps_valid = 1 from the cycle after the first win_end. RUN is terminal until reset.
- No vsync activity: at win_end fps_reg = 0 and sig4 keeps its last snapshot. The display is stale by design.
- Reset mid-window: all counters restart; no partial count is carried.

Optional Feature:
Macro TELEMETRY_SAMPLER_SAT_FLAG_EN.
- Defined: adds output sat_flags [6:0]. It updates with the snapshot; bit i = 1 when the value captured for sig i was clipped to SAT_MAX. Bit 4 is set when the raw frame count exceeded SAT_MAX. Reset value is 0.
- Not defined: no sat_flags port and no clip-tracking logic. Behaviour is otherwise identical.

Test Plan:
- Reset with vsync=1, release, hold vsync=1 for 10 cycles -> no frame_event; all sig = 0; fps_valid = 0.
- score_raw=37, rows_raw=20, cols_raw=10, then vsync 0->1 -> one cycle later sig0=37, sig5=20, sig6=10, frame_event=1 for exactly one cycle. Change score_raw to 99 without a new edge -> sig0 stays 37.
- score_raw=1000, lines_raw=511, level_raw=512 at an edge -> sig0=511, sig1=511, sig2=511. With TELEMETRY_SAMPLER_SAT_FLAG_EN: sat_flags[2:0] = 3'b101.
- CLK_HZ=100, vsync period 10 cycles -> fps_valid rises after cycle 100; the next edge gives sig4=10.
- CLK_HZ=100, a vsync edge placed exactly on win_end -> that frame counts in the ending window; the next window starts with frm_cnt=0.
- Assert reset at cycle 50 of a window with 4 frames counted, release, run 100 cycles with edges every 20 -> fps_valid=0 until the first full window, then sig4=5 after the next edge.
